// File: rtl/ept_sample_packetizer_pkg.sv
// ============================================================================
// ept_sample_packetizer_pkg : shared FSM encoding and packet framing constants
// Revision: 1.0
// ============================================================================
`default_nettype none

package ept_sample_packetizer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR    = 3'd1,
    ST_SEQ    = 3'd2,
    ST_LEN    = 3'd3,
    ST_PAY_HI = 3'd4,
    ST_PAY_LO = 3'd5,
    ST_CSUM   = 3'd6
  } pkt_state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Byte offsets of the packet fields; checksum follows the payload
  localparam int OFF_HDR     = 0;
  localparam int OFF_SEQ     = 1;
  localparam int OFF_LEN     = 2;
  localparam int OFF_PAYLOAD = 3;

  function automatic int pkt_bytes(input int samples);
    return OFF_PAYLOAD + 2 * samples + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ept_sample_fifo.sv
// ============================================================================
// ept_sample_fifo : synchronous sample FIFO with occupancy, full and empty
// Revision: 1.0
// ============================================================================
`default_nettype none

module ept_sample_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign full  = (count == FULL_LEVEL);
  assign empty = (count == '0);
  assign do_rd = rd_en & ~empty;
  // A write into a full FIFO still fits when the head leaves in the same cycle
  assign do_wr = wr_en & (~full | do_rd);

  assign rd_data = mem[rd_ptr];
  assign level   = count;

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/ept_sample_packetizer.sv
// ============================================================================
// ept_sample_packetizer : buffers samples and streams framed, checksummed
// packets byte-wise into the endpoint write channel.  Revision: 1.0
// ============================================================================
`default_nettype none

module ept_sample_packetizer
  import ept_sample_packetizer_pkg::*;
#(
  parameter int         SAMPLES_PER_PKT = 8,
  parameter int         FIFO_DEPTH      = 16,
  parameter logic [7:0] SYNC_BYTE       = SYNC_BYTE_DEFAULT
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          ENABLE,
  input  logic [15:0]                   SAMPLE_DATA,
  input  logic                          SAMPLE_VALID,
  output logic [7:0]                    TX_BYTE,
  output logic                          TX_VALID,
  input  logic                          TX_READY,
  output logic                          OVERFLOW,
  input  logic                          CLR_OVERFLOW,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
  output logic                          BUSY
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LW-1:0] START_LEVEL = LW'(SAMPLES_PER_PKT);
  localparam logic [7:0]    LEN_BYTE    = 8'(SAMPLES_PER_PKT);
  localparam logic [7:0]    LAST_SAMPLE = 8'(SAMPLES_PER_PKT - 1);

  pkt_state_t    state;
  pkt_state_t    next_state;
  logic [7:0]    seq;
  logic [7:0]    sent;
  logic [7:0]    csum;
  logic          overflow;
  logic [7:0]    tx_byte;
  logic          handshake;
  logic          wr_req;
  logic          pop;
  logic          ovf_set;
  logic [15:0]   head;
  logic [LW-1:0] fifo_level;
  logic          fifo_full;
  logic          fifo_empty;

  assign wr_req    = SAMPLE_VALID & ENABLE;
  assign TX_VALID  = (state != ST_IDLE);
  assign BUSY      = (state != ST_IDLE);
  assign handshake = TX_VALID & TX_READY;
  assign pop       = handshake & (state == ST_PAY_LO) & ~fifo_empty;
  assign ovf_set   = wr_req & fifo_full & ~pop;
  assign TX_BYTE   = tx_byte;
  assign OVERFLOW  = overflow;
  assign FIFO_LEVEL = fifo_level;

  ept_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk     (CLK),
    .rst     (RST),
    .wr_en   (wr_req),
    .wr_data (SAMPLE_DATA),
    .rd_en   (pop),
    .rd_data (head),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Byte on the channel is a pure function of state, so it holds while stalled
  always_comb begin
    next_state = state;
    tx_byte    = 8'h00;
    case (state)
      ST_IDLE: begin
        if (ENABLE && (fifo_level >= START_LEVEL)) begin
          next_state = ST_HDR;
        end
      end
      ST_HDR: begin
        tx_byte = SYNC_BYTE;
        if (TX_READY) next_state = ST_SEQ;
      end
      ST_SEQ: begin
        tx_byte = seq;
        if (TX_READY) next_state = ST_LEN;
      end
      ST_LEN: begin
        tx_byte = LEN_BYTE;
        if (TX_READY) next_state = ST_PAY_HI;
      end
      ST_PAY_HI: begin
        tx_byte = head[15:8];
        if (TX_READY) next_state = ST_PAY_LO;
      end
      ST_PAY_LO: begin
        tx_byte = head[7:0];
        if (TX_READY) begin
          next_state = (sent == LAST_SAMPLE) ? ST_CSUM : ST_PAY_HI;
        end
      end
      ST_CSUM: begin
        tx_byte = csum;
        if (TX_READY) next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      seq      <= 8'h00;
      sent     <= 8'h00;
      csum     <= 8'h00;
      overflow <= 1'b0;
    end else begin
      // A new drop outranks a clear in the same cycle
      overflow <= ovf_set | (overflow & ~CLR_OVERFLOW);
      if (handshake) begin
        if (state == ST_CSUM) begin
          csum <= 8'h00;
          seq  <= seq + 8'd1;
        end else begin
          csum <= csum ^ tx_byte;
        end
        if (state == ST_PAY_LO) begin
          sent <= (sent == LAST_SAMPLE) ? 8'h00 : sent + 8'd1;
        end
      end
    end
  end

endmodule

`default_nettype wire
